// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package nibble_serial_adder_pkg;

    // Width of one adder slice.
    localparam int unsigned NIB_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the nibble counter; kept at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned nibbles);
        int unsigned w;
        w = $clog2(nibbles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_nibble_adder4.sv
// Combinational 4-bit ripple-carry adder slice; the only arithmetic in the block.
module nibble_adder4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] w_carry;

    // Explicit ripple chain through NIB_W full-adder cells.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = cin;
        s          = '0;
        for (int i = 0; i < int'(NIB_W); i++) begin
            s[i]         = x[i] ^ y[i] ^ w_carry[i];
            w_carry[i+1] = (x[i] & y[i]) | (x[i] & w_carry[i]) | (y[i] & w_carry[i]);
        end
        cout = w_carry[NIB_W];
    end

endmodule : nibble_adder4

// File: rtl/nibble_serial_adder.sv
// Multi-word adder/subtractor that streams operands one nibble per clock
// through a 4-bit adder, carrying between nibbles in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                   cout,
    output logic                   overflow
);

    localparam int unsigned W     = NIB_W * NIBBLES;
    localparam int unsigned CNT_W = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic             w_run;
    logic             w_last;

    logic [W-1:0]     r_a_sh;
    logic [W-1:0]     r_b_sh;
    logic [W-1:0]     r_res_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_overflow;

    logic [W-1:0]     w_b_eff;
    logic [NIB_W-1:0] w_nib_sum;
    logic             w_nib_cout;
    logic [W-1:0]     w_res_next;

    // Nibble slice of the datapath.
    nibble_adder4 u_adder (
        .x    (r_a_sh[NIB_W-1:0]),
        .y    (r_b_sh[NIB_W-1:0]),
        .cin  (r_carry),
        .s    (w_nib_sum),
        .cout (w_nib_cout)
    );

    // Subtraction is a + ~b + 1; the +1 enters through the initial carry.
    assign w_b_eff    = sub ? ~b : b;
    assign w_res_next = {w_nib_sum, r_res_sh[W-1:NIB_W]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_run        = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_DONE;
                    w_last       = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand shift registers, carry and nibble counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_load) begin
            r_a_sh   <= a;
            r_b_sh   <= w_b_eff;
            r_res_sh <= '0;
            r_carry  <= sub ? 1'b1 : cin;
            r_cnt    <= '0;
            r_a_msb  <= a[W-1];
            r_b_msb  <= w_b_eff[W-1];
        end else if (w_run) begin
            r_a_sh   <= {{NIB_W{1'b0}}, r_a_sh[W-1:NIB_W]};
            r_b_sh   <= {{NIB_W{1'b0}}, r_b_sh[W-1:NIB_W]};
            r_res_sh <= w_res_next;
            r_carry  <= w_nib_cout;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Status outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_RUN);
            r_done <= (w_next_state == ST_DONE);
        end
    end

    // Result registers update only on the final nibble edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_sum      <= w_res_next;
            r_cout     <= w_nib_cout;
            r_overflow <= (r_a_msb == r_b_msb) && (w_nib_sum[NIB_W-1] != r_a_msb);
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int total;
    int bad;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                          input logic tsub);
        a     = ta;
        b     = tb;
        cin   = tcin;
        sub   = tsub;
        start = 1'b1;
    endtask

    // Runs from the start edge until done; edges counts the start edge itself.
    task automatic wait_done(input string tag, input bit poke, input bit chk_hold,
                             input logic [15:0] hold);
        int cyc;
        int busy_cnt;
        cyc      = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (!done) begin
                if (poke) begin
                    start = 1'b1;
                    a     = 16'hFFFF;
                    b     = 16'hFFFF;
                end
                if (chk_hold) check({tag, "_hold"}, 32'(sum), 32'(hold));
            end
        end while (!done && cyc < 30);
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'd5);
        check({tag, "_busy"}, 32'(busy_cnt), 32'd4);
    endtask

    task automatic check_res(input string tag, input logic [15:0] es, input logic ec,
                             input logic eo);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        int seen_done;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_done("add", 1'b0, 1'b1, 16'h0000);
        check_res("add", 16'h2345, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);

        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done("cch", 1'b0, 1'b1, 16'h2345);
        check_res("cch", 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        launch(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        wait_done("ovp", 1'b0, 1'b0, 16'h0000);
        check_res("ovp", 16'h8000, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        launch(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done("sub1", 1'b0, 1'b0, 16'h0000);
        check_res("sub1", 16'hFFFE, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        launch(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done("sub2", 1'b0, 1'b0, 16'h0000);
        check_res("sub2", 16'h7FFF, 1'b1, 1'b1);
        @(posedge clk);
        #1;

        // Reset during the second RUN cycle aborts the operation.
        launch(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("abort_nodone", 32'(seen_done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done("post_rst", 1'b0, 1'b1, 16'h0000);
        check_res("post_rst", 16'h0002, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // start pulses during RUN must not disturb the running operation.
        launch(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_done("ignore", 1'b1, 1'b1, 16'h0002);
        check_res("ignore", 16'h2345, 1'b0, 1'b0);

        // Back-to-back start in the DONE cycle; first result holds meanwhile.
        launch(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        wait_done("b2b", 1'b0, 1'b1, 16'h2345);
        check_res("b2b", 16'h1010, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("b2b_idle_done", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential multi-word adder/subtractor that feeds a 4-bit ripple-carry adder one nibble per clock. It keeps the carry in a register between nibbles. It accepts two `4*NIBBLES`-bit operands on a start pulse and returns sum, carry-out and signed overflow with a one-cycle done pulse. It sits directly upstream of the 4-bit adder datapath: it sequences operands into the adder and consumes the adder's sum and carry-out.

## Interface
- `NIBBLES`, default 4: operand width in nibbles (W = 4*NIBBLES); legal range ≥ 2.
- Clocking (already decided): one clock; reset is synchronous and active-low.
- `clk` in 1: rising-edge clock, sole clock.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: request; sampled only in IDLE or DONE.
- `sub` in 1: 0 = a+b+cin, 1 = a−b (cin ignored).
- `cin` in 1: carry-in for add.
- `a` in W: operand A, sampled with start.
- `b` in W: operand B, sampled with start.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse, result valid.
- `sum` out W: registered result.
- `cout` out 1: carry-out of MSB; for sub, 1 = no borrow.
- `overflow` out 1: two's-complement signed overflow.

## Operation
- FSM states IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when nibble counter = NIBBLES−1.
  - DONE→RUN on `start`, otherwise DONE→IDLE.
- Load (start accepted):
  - `a_sh`←a.
  - `b_sh`←(sub ? ~b : b).
  - `carry`←(sub ? 1 : cin).
  - `cnt`←0.
  - Latch `a_msb`=a[W−1] and `b_msb`=b_eff[W−1].
- RUN, each cycle:
  - The adder sees `a_sh[3:0]`, `b_sh[3:0]`, `carry`.
  - Its sum nibble shifts into the top of internal `res_sh`; `res_sh`, `a_sh`, `b_sh` shift right by 4.
  - `carry`←adder cout; `cnt`++.
- Final RUN edge:
  - `sum`←final `res_sh` value, including the last nibble.
  - `cout`←adder cout.
  - `overflow`←(a_msb==b_msb) && (sum[W−1]≠a_msb).
- Outputs `sum`/`cout`/`overflow` change only on the final RUN edge. They hold through DONE, IDLE and all of the next RUN.
- `start` while in RUN is ignored; no queuing.
- Width: all arithmetic is modulo 2^W; the carry beyond the MSB appears only on `cout`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `sum` 0, `cout` 0, `overflow` 0, `cnt` 0, `carry` 0.
- `start` sampled at edge E0 → `busy` high from E0 to E(NIBBLES).
- Results are loaded at edge E(NIBBLES); `done` is high for exactly the cycle after E(NIBBLES). Latency = NIBBLES clocks.
- Back-to-back: `start` in the DONE cycle is accepted, giving one operation per NIBBLES+1 clocks. The outputs of the first operation hold until the second completes.
- Reset mid-RUN:
  - The operation aborts; no `done`.
  - All outputs return to their reset values at that edge.
  - The next `start` after `rst_n` returns high operates normally.
- `rst_n` low in the same cycle as `start`: reset wins.

## Structure
- A shared package holds the FSM state enum (IDLE/RUN/DONE), the nibble width constant 4, and a `cnt` width function `$clog2(NIBBLES)`.
- One sub-module, `nibble_adder4`: a combinational 4-bit adder with ports (x[3:0], y[3:0], cin, s[3:0], cout). It is the only arithmetic in the block.
- The controller contains the FSM, shift registers, carry register and output registers.

## Test plan
All cases use NIBBLES=4.
- Add: a=0x1234, b=0x1111, cin=0, sub=0 → sum=0x2345, cout=0, overflow=0. `done` exactly 4 edges after the start edge; `busy` high 4 cycles.
- Carry chain: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, overflow=1, cout=0.
- Subtract: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, overflow=0. a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, overflow=1.
- Reset mid-op: start a=0x1234, b=0x1111; drive `rst_n`=0 on the 2nd RUN cycle → no `done`, sum=0. The next start (0x0001+0x0001) → 0x0002.
- Protocol:
  - `start` pulses during RUN are ignored (the result is that of the first operands).
  - `start` in the DONE cycle with a=0x0F0F, b=0x0101 → second `done` 5 cycles after the first, sum=0x1010.
  - The first result holds until then.
